// File: rtl/draw_hp_bar_dog_if.sv
// VGA stream bundle: pixel timing plus 12-bit rgb, with one modport per direction.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_hp_bar_dog.sv
// Dog health FSM (ALIVE/COOLDOWN/DEAD) and HP bar overlay on a 1-cycle delayed VGA stream.
// Optional low-HP blinking of the fill is enabled by defining HP_BAR_BLINK_EN.
module draw_hp_bar_dog #(
    parameter int unsigned MAX_HP         = 100,
    parameter int unsigned BAR_X          = 900,
    parameter int unsigned BAR_Y          = 410,
    parameter int unsigned BAR_H          = 12,
    parameter int unsigned COOLDOWN_TICKS = 32_500_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hit_dog,
    input  logic [6:0]   damage,
    input  logic         new_game,
    output logic [6:0]   dog_hp,
    output logic         dog_dead,
    vga_if.vga_in        vga_in,
    vga_if.vga_out       vga_out
);

    localparam int unsigned CntW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(COOLDOWN_TICKS - 1);
    localparam logic [6:0] HpFull = 7'(MAX_HP);

    typedef enum logic [1:0] {StAlive, StCooldown, StDead} state_e;

    state_e          state_q, state_d;
    logic [6:0]      hp_q, hp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hit_prev_q;
    logic            dead_q, dead_d;
    logic            hit_rise;
    logic [6:0]      hp_hit;

    // ---------------- health FSM ----------------
    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        cnt_d    = cnt_q;
        hit_rise = hit_dog & ~hit_prev_q;
        hp_hit   = (hp_q > damage) ? hp_q - damage : 7'd0;
        if (new_game) begin
            state_d = StAlive;
            hp_d    = HpFull;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StAlive: begin
                    if (hit_rise) begin
                        hp_d    = hp_hit;
                        cnt_d   = '0;
                        state_d = (hp_hit == 7'd0) ? StDead : StCooldown;
                    end
                end
                StCooldown: begin
                    if (cnt_q == CntLast) begin
                        state_d = StAlive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDead:  state_d = StDead;
                default: state_d = StAlive;
            endcase
        end
        dead_d = (state_d == StDead);
    end

    // History resets to 1 so a level already high at reset release is not a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StAlive;
            hp_q       <= HpFull;
            cnt_q      <= '0;
            hit_prev_q <= 1'b1;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            hit_prev_q <= hit_dog;
            dead_q     <= dead_d;
        end
    end

    assign dog_hp   = hp_q;
    assign dog_dead = dead_q;

    // ---------------- VGA delay stage ----------------
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= vga_in.hcount;
            vcount_q <= vga_in.vcount;
            hsync_q  <= vga_in.hsync;
            vsync_q  <= vga_in.vsync;
            hblnk_q  <= vga_in.hblnk;
            vblnk_q  <= vga_in.vblnk;
            rgb_q    <= vga_in.rgb;
        end
    end

`ifdef HP_BAR_BLINK_EN
    logic       vsync_prev_q;
    logic [4:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (vsync_q && !vsync_prev_q) frame_d = frame_q + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            frame_q      <= '0;
        end else begin
            vsync_prev_q <= vsync_q;
            frame_q      <= frame_d;
        end
    end
`endif

    // ---------------- bar compositing ----------------
    logic [31:0] h32, v32, col, hp32;
    logic        in_bar, outline, low_hp;
    logic [11:0] fill, rgb_mix;

    always_comb begin
        h32     = {21'd0, hcount_q};
        v32     = {21'd0, vcount_q};
        hp32    = {25'd0, hp_q};
        col     = h32 - BAR_X - 32'd1;
        in_bar  = !hblnk_q && !vblnk_q &&
                  (h32 >= BAR_X) && (h32 < BAR_X + MAX_HP + 2) &&
                  (v32 >= BAR_Y) && (v32 < BAR_Y + BAR_H);
        outline = (h32 == BAR_X) || (h32 == BAR_X + MAX_HP + 1) ||
                  (v32 == BAR_Y) || (v32 == BAR_Y + BAR_H - 1);
        low_hp  = (hp32 <= MAX_HP / 4);
        fill    = low_hp ? 12'hF00 : 12'h0C0;
`ifdef HP_BAR_BLINK_EN
        if (low_hp && (hp_q != 7'd0) && frame_q[4]) fill = 12'h333;
`endif
        rgb_mix = rgb_q;
        if (in_bar) begin
            if (outline)          rgb_mix = 12'hFFF;
            else if (col < hp32)  rgb_mix = fill;
            else                  rgb_mix = 12'h333;
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = rgb_mix;

endmodule

// File: tb/tb_draw_hp_bar_dog.sv
// Self-checking bench for draw_hp_bar_dog: cycle-level health/pixel model plus directed literals.
module tb_draw_hp_bar_dog;

    localparam int MAXHP = 100;
    localparam int BX    = 900;
    localparam int BY    = 410;
    localparam int BH    = 12;
    localparam int T     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hit_dog = 1'b0;
    logic [6:0] damage = '0;
    logic       new_game = 1'b0;
    logic [6:0] dog_hp;
    logic       dog_dead;

    vga_if vin ();
    vga_if vout ();

    draw_hp_bar_dog #(
        .MAX_HP(MAXHP), .BAR_X(BX), .BAR_Y(BY), .BAR_H(BH), .COOLDOWN_TICKS(T)
    ) dut (
        .clk(clk), .rst(rst), .hit_dog(hit_dog), .damage(damage), .new_game(new_game),
        .dog_hp(dog_hp), .dog_dead(dog_dead), .vga_in(vin), .vga_out(vout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: hits open again T+1 edges after an accepted one; bar drawn from plain geometry.
    int          m_hp, e, open_at, frames;
    bit          m_dead, m_prev;
    int          d_h, d_v;
    bit          d_hs, d_vs, d_hb, d_vb, dd_vs;
    logic [11:0] d_rgb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hp <= MAXHP; m_dead <= 0; m_prev <= 1; e <= 0; open_at <= 0; frames <= 0;
            d_h <= 0; d_v <= 0; d_hs <= 0; d_vs <= 0; d_hb <= 0; d_vb <= 0; dd_vs <= 0;
            d_rgb <= '0;
        end else begin
            e <= e + 1;
            if (new_game) begin
                m_hp <= MAXHP; m_dead <= 0; open_at <= 0;
            end else if (hit_dog && !m_prev && !m_dead && e >= open_at) begin
                if (int'(damage) >= m_hp) begin
                    m_hp <= 0; m_dead <= 1;
                end else begin
                    m_hp <= m_hp - int'(damage); open_at <= e + T + 1;
                end
            end
            m_prev <= hit_dog;
            if (d_vs && !dd_vs) frames <= frames + 1;
            dd_vs <= d_vs;
            d_h <= int'(vin.hcount); d_v <= int'(vin.vcount);
            d_hs <= vin.hsync; d_vs <= vin.vsync; d_hb <= vin.hblnk; d_vb <= vin.vblnk;
            d_rgb <= vin.rgb;
        end
    end

    function automatic logic [11:0] exp_pix(int h, int v, bit hb, bit vb, logic [11:0] rin,
                                            int hp, bit dark);
        int c;
        if (hb || vb) return rin;
        if (h < BX || h >= BX + MAXHP + 2 || v < BY || v >= BY + BH) return rin;
        if (h == BX || h == BX + MAXHP + 1 || v == BY || v == BY + BH - 1) return 12'hFFF;
        c = h - BX - 1;
        if (c >= hp) return 12'h333;
        if (hp <= MAXHP / 4) return dark ? 12'h333 : 12'hF00;
        return 12'h0C0;
    endfunction

    function automatic bit blink_dark(int f);
`ifdef HP_BAR_BLINK_EN
        return (f % 32) >= 16;
`else
        return (f < 0);
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dog_hp", 32'(dog_hp), m_hp);
            chk("dog_dead", 32'(dog_dead), 32'(m_dead));
            chk("hcount", 32'(vout.hcount), d_h);
            chk("vcount", 32'(vout.vcount), d_v);
            chk("sync", {30'd0, vout.hsync, vout.vsync}, {30'd0, d_hs, d_vs});
            chk("blnk", {30'd0, vout.hblnk, vout.vblnk}, {30'd0, d_hb, d_vb});
            chk("rgb", 32'(vout.rgb),
                32'(exp_pix(d_h, d_v, d_hb, d_vb, d_rgb, m_hp, blink_dark(frames))));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_hit(input int d);
        damage  = 7'(d);
        hit_dog = 1'b1;
        tick(1);
        hit_dog = 1'b0;
    endtask

    task automatic set_pix(input int h, input int v, input bit hb, input logic [11:0] rin);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.rgb    = rin;
    endtask

    typedef struct {
        int          h;
        int          v;
        bit          hb;
        logic [11:0] rin;
        logic [11:0] exp;
    } pix_t;

    pix_t tbl[9];
    logic [11:0] blink_exp;

    initial begin
        set_pix(0, 0, 1'b0, 12'h000);
        vin.hsync = 1'b0; vin.vsync = 1'b0; vin.vblnk = 1'b0;
        tick(3);
        chk_en = 1'b1;
        chk("rst_hp", 32'(dog_hp), 100);
        chk("rst_dead", 32'(dog_dead), 0);
        chk("rst_rgb", 32'(vout.rgb), 0);
        rst = 1'b0;
        tick(2);

        // First hit, then a hit during cooldown that must be ignored
        pulse_hit(30);
        chk("hit30_hp", 32'(dog_hp), 70);
        set_pix(BX + 5, BY + 5, 1'b0, 12'h123);
        tick(1);
        chk("green_fill", 32'(vout.rgb), 32'h0C0);
        pulse_hit(30);
        chk("cooldown_ignore", 32'(dog_hp), 70);
        tick(20);

        // Held level across a full cooldown: one decrement only
        damage = 7'd10; hit_dog = 1'b1;
        tick(T + 10);
        chk("held_hp", 32'(dog_hp), 60);
        hit_dog = 1'b0;
        tick(20);

        new_game = 1'b1; tick(1); new_game = 1'b0;
        chk("newgame_hp", 32'(dog_hp), 100);
        pulse_hit(60);
        chk("hit60a_hp", 32'(dog_hp), 40);
        tick(20);
        pulse_hit(60);
        chk("clamp_hp", 32'(dog_hp), 0);
        chk("dead", 32'(dog_dead), 1);
        tick(20);
        pulse_hit(5);
        chk("dead_ignore", 32'(dog_hp), 0);

        // new_game wins over a simultaneous hit edge
        new_game = 1'b1; hit_dog = 1'b1; damage = 7'd60;
        tick(1);
        new_game = 1'b0;
        chk("ng_prio_hp", 32'(dog_hp), 100);
        chk("ng_prio_dead", 32'(dog_dead), 0);
        tick(3);
        chk("ng_level_hp", 32'(dog_hp), 100);
        hit_dog = 1'b0;
        tick(1);

        pulse_hit(0);
        chk("dmg0_hp", 32'(dog_hp), 100);
        tick(2);
        pulse_hit(5);
        chk("dmg0_cooldown", 32'(dog_hp), 100);
        tick(20);
        pulse_hit(80);
        chk("hp20", 32'(dog_hp), 20);
        tick(20);

        tbl[0] = '{BX + 1,       BY + 5,  1'b0, 12'h123, 12'hF00};
        tbl[1] = '{BX + 21,      BY + 5,  1'b0, 12'h123, 12'h333};
        tbl[2] = '{BX + 20,      BY + 5,  1'b0, 12'h123, 12'hF00};
        tbl[3] = '{BX,           BY,      1'b0, 12'h123, 12'hFFF};
        tbl[4] = '{BX + 101,     BY + 11, 1'b0, 12'h123, 12'hFFF};
        tbl[5] = '{BX + 102,     BY + 5,  1'b0, 12'h456, 12'h456};
        tbl[6] = '{BX + 5,       BY + 12, 1'b0, 12'h789, 12'h789};
        tbl[7] = '{BX + 5,       BY + 5,  1'b1, 12'hABC, 12'hABC};
        tbl[8] = '{BX - 1,       BY + 5,  1'b0, 12'hDEF, 12'hDEF};
        foreach (tbl[i]) begin
            set_pix(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].rin);
            tick(1);
            chk($sformatf("pix%0d_rgb", i), 32'(vout.rgb), 32'(tbl[i].exp));
            chk($sformatf("pix%0d_hcount", i), 32'(vout.hcount), tbl[i].h);
        end

        // Low-HP fill across 20 vsync pulses
        set_pix(BX + 1, BY + 5, 1'b0, 12'h000);
        for (int i = 1; i <= 20; i++) begin
            vin.vsync = 1'b1; tick(1);
            vin.vsync = 1'b0; tick(2);
`ifdef HP_BAR_BLINK_EN
            blink_exp = (i >= 16) ? 12'h333 : 12'hF00;
`else
            blink_exp = 12'hF00;
`endif
            chk($sformatf("blink_f%0d", i), 32'(vout.rgb), 32'(blink_exp));
        end

        // Reset mid-cooldown, level held through release
        new_game = 1'b1; tick(1); new_game = 1'b0;
        pulse_hit(60);
        chk("pre_rst_hp", 32'(dog_hp), 40);
        tick(2);
        rst = 1'b1; hit_dog = 1'b1;
        #1;
        chk("async_rst_hp", 32'(dog_hp), 100);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst_level", 32'(dog_hp), 100);
        hit_dog = 1'b0; tick(1);
        hit_dog = 1'b1; tick(1);
        chk("post_rst_hit", 32'(dog_hp), 40);
        hit_dog = 1'b0;
        tick(20);

        pulse_hit(60);
        chk("dead2", 32'(dog_dead), 1);
        set_pix(BX + 1, BY + 5, 1'b0, 12'h000);
        tick(1);
        chk("hp0_interior", 32'(vout.rgb), 32'h333);
        set_pix(BX, BY + 3, 1'b0, 12'h000);
        tick(1);
        chk("hp0_outline", 32'(vout.rgb), 32'hFFF);
        tick(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_hp_bar_dog.md
DRAW_HP_BAR_DOG -- requirements
Module: draw_hp_bar_dog

Interface
REQ-001 The module SHALL have parameter MAX_HP, default 100: starting hit points, equal to the bar fill width in pixels.
REQ-002 The module SHALL have parameter BAR_X, default 900: left pixel column of the bar outline.
REQ-003 The module SHALL have parameter BAR_Y, default 410: top pixel row of the bar outline.
REQ-004 The module SHALL have parameter BAR_H, default 12: outline height in pixels.
REQ-005 The module SHALL have parameter COOLDOWN_TICKS, default 32_500_000: invulnerability window in clk cycles (0.5 s at 65 MHz).
REQ-006 Port clk  in  1  pixel clock; all logic is clocked on its rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-high.
REQ-008 Port hit_dog  in  1  level hit request from the collision logic.
REQ-009 Port damage  in  7  HP to subtract per accepted hit.
REQ-010 Port new_game  in  1  single-cycle pulse that restores full HP.
REQ-011 Port dog_hp  out  7  current HP.
REQ-012 Port dog_dead  out  1  high while in state DEAD.
REQ-013 Port vga_in  vga_if.vga_in  --  timing plus rgb from the upstream draw stage.
REQ-014 Port vga_out  vga_if.vga_out  --  timing plus composited rgb.

Function
REQ-015 The health logic SHALL be an FSM with states ALIVE, COOLDOWN and DEAD.
REQ-016 A hit SHALL be accepted only on a rising edge of hit_dog (0 in the previous cycle, 1 now) while the FSM is in ALIVE.
REQ-017 On an accepted hit, dog_hp SHALL become max(dog_hp - damage, 0) on the next clk edge.
REQ-018 On that same edge the FSM SHALL go to DEAD if the result is 0, otherwise to COOLDOWN with the cooldown counter cleared.
REQ-019 In COOLDOWN the counter SHALL increment every cycle; on the cycle it equals COOLDOWN_TICKS-1 the FSM SHALL return to ALIVE and the counter SHALL clear.
REQ-020 Hits SHALL be ignored in COOLDOWN and in DEAD; a level held across a COOLDOWN exit SHALL NOT count as a new hit.
REQ-021 new_game SHALL set dog_hp to MAX_HP, the state to ALIVE and the counter to 0 from any state, taking priority over a simultaneous hit.
REQ-022 A hit with damage = 0 SHALL still enter COOLDOWN, and dog_hp SHALL be unchanged.
REQ-023 dog_dead SHALL be a registered output that is 1 exactly when the state is DEAD.
REQ-024 All vga_in timing signals (hcount, vcount, hsync, vsync, hblnk, vblnk) and rgb SHALL be registered once, giving vga_out a latency of exactly 1 cycle.
REQ-025 The rgb output SHALL be computed combinationally from the delayed signals and the current dog_hp.
REQ-026 Bar region: hcount_d in [BAR_X, BAR_X+MAX_HP+2), vcount_d in [BAR_Y, BAR_Y+BAR_H), and both blanking signals low.
REQ-027 Outline pixels (first or last row or column of the region) SHALL be 12'hFFF.
REQ-028 An interior pixel at column c = hcount_d-BAR_X-1 SHALL be the fill colour if c < dog_hp, otherwise 12'h333.
REQ-029 The fill colour SHALL be 12'h0C0 when dog_hp > MAX_HP/4 and 12'hF00 otherwise.
REQ-030 Pixels outside the bar region SHALL pass the delayed rgb unchanged.
REQ-031 When dog_hp = 0 the bar SHALL show the outline and an all-12'h333 interior.

Reset
REQ-032 While rst is high, the module SHALL hold dog_hp = MAX_HP, state ALIVE, counter 0, dog_dead 0, and all delayed VGA registers and rgb_out at 0.
REQ-033 Reset mid-COOLDOWN or in DEAD SHALL abort that state immediately.
REQ-034 The first hit after reset is released SHALL need a 0-to-1 edge: the hit_dog history register resets to 1.

Configuration
REQ-035 With HP_BAR_BLINK_EN defined, a 5-bit frame counter SHALL increment on each rising edge of the delayed vsync.
REQ-036 With HP_BAR_BLINK_EN defined and 0 < dog_hp <= MAX_HP/4, fill pixels SHALL show 12'h333 while frame counter bit 4 is 1.
REQ-037 Without HP_BAR_BLINK_EN, the fill SHALL be steady and no frame counter SHALL exist.

Verification
REQ-038 Reset, then one hit_dog pulse with damage=30 -> dog_hp 70 one cycle later, state COOLDOWN, fill green.
REQ-039 hit_dog held high for COOLDOWN_TICKS+10 cycles (COOLDOWN_TICKS overridden to 16) -> exactly one decrement.
REQ-040 Hits of 60 then 60 separated by cooldown -> dog_hp 40 then 0 with no underflow wrap; dog_dead=1.
REQ-041 dog_dead=1, then new_game asserted together with hit_dog -> dog_hp 100, dog_dead 0, no decrement.
REQ-042 dog_hp=20: scan pixel (BAR_X+1, BAR_Y+5) -> 12'hF00; (BAR_X+21, BAR_Y+5) -> 12'h333; (BAR_X, BAR_Y) -> 12'hFFF; every output 1 cycle after input.
REQ-043 With HP_BAR_BLINK_EN defined and dog_hp=20 -> fill alternates every 16 frames; without the macro and dog_hp=20 -> fill constant 12'hF00.
